// File: rtl/menshen_cfg_data_arbiter.sv
// menshen_cfg_data_arbiter
// Packet-atomic 2:1 AXI-Stream arbiter that merges host data packets with
// reconfiguration packets ahead of the Menshen RMT pipeline. Config packets
// win arbitration, but a burst counter limits how many consecutive config
// packets can go through while data is waiting. A single registered output
// slice carries tdata together with its sideband.
// Optional feature: define ARB_STATS_EN to add packet/stall statistics outputs.
module menshen_cfg_data_arbiter #(
  parameter int DATA_WIDTH    = 512,
  parameter int QID_WIDTH     = 11,
  parameter int MAX_CFG_BURST = 4
) (
  input  logic                    axis_aclk,
  input  logic                    aresetn,

  input  logic [DATA_WIDTH-1:0]   s_axis_data_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_data_tkeep,
  input  logic [31:0]             s_axis_data_tuser,
  input  logic [QID_WIDTH-1:0]    s_axis_data_tqid,
  input  logic                    s_axis_data_tvalid,
  input  logic                    s_axis_data_tlast,
  output logic                    s_axis_data_tready,

  input  logic [DATA_WIDTH-1:0]   s_axis_cfg_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_cfg_tkeep,
  input  logic [31:0]             s_axis_cfg_tuser,
  input  logic [QID_WIDTH-1:0]    s_axis_cfg_tqid,
  input  logic                    s_axis_cfg_tvalid,
  input  logic                    s_axis_cfg_tlast,
  output logic                    s_axis_cfg_tready,

  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [31:0]             m_axis_tuser,
  output logic [QID_WIDTH-1:0]    m_axis_tqid,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
`ifdef ARB_STATS_EN
  output logic [31:0]             stat_data_pkts,
  output logic [31:0]             stat_cfg_pkts,
  output logic [31:0]             stat_stall_cyc,
`endif
  output logic                    arb_busy
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(MAX_CFG_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_CFG_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CFG  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] cfg_cnt;
  logic                 data_wait;

  logic                  slice_ready;
  logic                  data_accept;
  logic                  cfg_accept;
  logic                  beat_accept;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [KEEP_WIDTH-1:0] sel_tkeep;
  logic [31:0]           sel_tuser;
  logic [QID_WIDTH-1:0]  sel_tqid;
  logic                  sel_tlast;

  // The slice can take a new beat when it is empty or being drained this cycle
  assign slice_ready        = !m_axis_tvalid || m_axis_tready;
  assign s_axis_data_tready = (state_q == DATA) && slice_ready;
  assign s_axis_cfg_tready  = (state_q == CFG) && slice_ready;
  assign data_accept        = s_axis_data_tvalid && s_axis_data_tready;
  assign cfg_accept         = s_axis_cfg_tvalid && s_axis_cfg_tready;
  assign beat_accept        = data_accept || cfg_accept;
  assign arb_busy           = (state_q != IDLE);

  assign sel_tdata = (state_q == CFG) ? s_axis_cfg_tdata : s_axis_data_tdata;
  assign sel_tkeep = (state_q == CFG) ? s_axis_cfg_tkeep : s_axis_data_tkeep;
  assign sel_tuser = (state_q == CFG) ? s_axis_cfg_tuser : s_axis_data_tuser;
  assign sel_tqid  = (state_q == CFG) ? s_axis_cfg_tqid  : s_axis_data_tqid;
  assign sel_tlast = (state_q == CFG) ? s_axis_cfg_tlast : s_axis_data_tlast;

  // Next-state: pick a port in IDLE, then hold the lock until the packet's last beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s_axis_cfg_tvalid && (!s_axis_data_tvalid || (cfg_cnt < CNT_MAX))) begin
          state_d = CFG;
        end else if (s_axis_data_tvalid) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (data_accept && s_axis_data_tlast) begin
          state_d = IDLE;
        end
      end
      CFG: begin
        if (cfg_accept && s_axis_cfg_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Starvation guard: count config packets that ran while data was waiting
  always_ff @(posedge axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_cnt   <= '0;
      data_wait <= 1'b0;
    end else if ((state_q == IDLE) && (state_d == CFG)) begin
      data_wait <= s_axis_data_tvalid;
      if (!s_axis_data_tvalid) begin
        cfg_cnt <= '0;
      end
    end else if (data_accept && s_axis_data_tlast) begin
      cfg_cnt <= '0;
    end else if (cfg_accept && s_axis_cfg_tlast && data_wait && (cfg_cnt < CNT_MAX)) begin
      cfg_cnt <= cfg_cnt + 1'b1;
    end
  end

  // Output slice: load on accept, hold while stalled, empty once drained
  always_ff @(posedge axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tqid   <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (beat_accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_tdata;
      m_axis_tkeep  <= sel_tkeep;
      m_axis_tuser  <= sel_tuser;
      m_axis_tqid   <= sel_tqid;
      m_axis_tlast  <= sel_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef ARB_STATS_EN
  // Free-running wrap-around statistics for completed packets and output stalls
  always_ff @(posedge axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_data_pkts <= '0;
      stat_cfg_pkts  <= '0;
      stat_stall_cyc <= '0;
    end else begin
      if (data_accept && s_axis_data_tlast) begin
        stat_data_pkts <= stat_data_pkts + 32'd1;
      end
      if (cfg_accept && s_axis_cfg_tlast) begin
        stat_cfg_pkts <= stat_cfg_pkts + 32'd1;
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        stat_stall_cyc <= stat_stall_cyc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_menshen_cfg_data_arbiter.sv
// Testbench for menshen_cfg_data_arbiter
// Random packets on both ports; expected output order comes from a packet-level
// arbitration model and is checked beat by beat by an independent monitor.
// Build with ARB_STATS_EN defined to also check the statistics outputs.
module tb_menshen_cfg_data_arbiter;

  localparam int DW   = 512;
  localparam int KW   = DW / 8;
  localparam int QW   = 11;
  localparam int MAXB = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [31:0]   user;
    logic [QW-1:0] qid;
    logic          last;
  } beat_t;

  logic          clk;
  logic          aresetn;
  logic [DW-1:0] s_axis_data_tdata;
  logic [KW-1:0] s_axis_data_tkeep;
  logic [31:0]   s_axis_data_tuser;
  logic [QW-1:0] s_axis_data_tqid;
  logic          s_axis_data_tvalid;
  logic          s_axis_data_tlast;
  logic          s_axis_data_tready;
  logic [DW-1:0] s_axis_cfg_tdata;
  logic [KW-1:0] s_axis_cfg_tkeep;
  logic [31:0]   s_axis_cfg_tuser;
  logic [QW-1:0] s_axis_cfg_tqid;
  logic          s_axis_cfg_tvalid;
  logic          s_axis_cfg_tlast;
  logic          s_axis_cfg_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [31:0]   m_axis_tuser;
  logic [QW-1:0] m_axis_tqid;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          arb_busy;
`ifdef ARB_STATS_EN
  logic [31:0]   stat_data_pkts;
  logic [31:0]   stat_cfg_pkts;
  logic [31:0]   stat_stall_cyc;
`endif

  menshen_cfg_data_arbiter #(
    .DATA_WIDTH   (DW),
    .QID_WIDTH    (QW),
    .MAX_CFG_BURST(MAXB)
  ) dut (
    .axis_aclk          (clk),
    .aresetn            (aresetn),
    .s_axis_data_tdata  (s_axis_data_tdata),
    .s_axis_data_tkeep  (s_axis_data_tkeep),
    .s_axis_data_tuser  (s_axis_data_tuser),
    .s_axis_data_tqid   (s_axis_data_tqid),
    .s_axis_data_tvalid (s_axis_data_tvalid),
    .s_axis_data_tlast  (s_axis_data_tlast),
    .s_axis_data_tready (s_axis_data_tready),
    .s_axis_cfg_tdata   (s_axis_cfg_tdata),
    .s_axis_cfg_tkeep   (s_axis_cfg_tkeep),
    .s_axis_cfg_tuser   (s_axis_cfg_tuser),
    .s_axis_cfg_tqid    (s_axis_cfg_tqid),
    .s_axis_cfg_tvalid  (s_axis_cfg_tvalid),
    .s_axis_cfg_tlast   (s_axis_cfg_tlast),
    .s_axis_cfg_tready  (s_axis_cfg_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tuser       (m_axis_tuser),
    .m_axis_tqid        (m_axis_tqid),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tready      (m_axis_tready),
`ifdef ARB_STATS_EN
    .stat_data_pkts     (stat_data_pkts),
    .stat_cfg_pkts      (stat_cfg_pkts),
    .stat_stall_cyc     (stat_stall_cyc),
`endif
    .arb_busy           (arb_busy)
  );

  int    n_checks = 0;
  int    n_fails  = 0;
  bit    mon_en   = 0;
  int    rdy_mode = 0;
  int    model_cnt = 0;
  int    tot_data_pkts = 0;
  int    tot_cfg_pkts  = 0;
  int    tb_stall = 0;

  beat_t data_drive_q[$];
  beat_t cfg_drive_q[$];
  beat_t data_model_q[$];
  beat_t cfg_model_q[$];
  int    data_len_q[$];
  int    cfg_len_q[$];
  beat_t exp_q[$];

  beat_t prev_beat;
  bit    prev_stall = 0;

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0: b.keep = '0;
      1: b.keep = '1;
      default: for (int i = 0; i < KW / 32; i++) b.keep[i*32 +: 32] = $urandom;
    endcase
    b.user = $urandom;
    b.qid  = QW'($urandom);
    b.last = last;
    return b;
  endfunction

  task automatic gen_packets(input int nd, input int nc, input int fixed_len);
    for (int p = 0; p < nd + nc; p++) begin
      int len;
      len = (fixed_len > 0) ? fixed_len : $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        beat_t b;
        b = rand_beat(i == len - 1);
        if (p < nd) begin
          data_drive_q.push_back(b);
          data_model_q.push_back(b);
        end else begin
          cfg_drive_q.push_back(b);
          cfg_model_q.push_back(b);
        end
      end
      if (p < nd) data_len_q.push_back(len);
      else        cfg_len_q.push_back(len);
    end
  endtask

  // Packet-level order: config first unless data is waiting and the burst allowance is used up
  task automatic build_expected();
    while (data_len_q.size() != 0 || cfg_len_q.size() != 0) begin
      int len;
      if (cfg_len_q.size() != 0 && (data_len_q.size() == 0 || model_cnt < MAXB)) begin
        len = cfg_len_q.pop_front();
        for (int i = 0; i < len; i++) exp_q.push_back(cfg_model_q.pop_front());
        if (data_len_q.size() != 0) model_cnt = (model_cnt < MAXB) ? model_cnt + 1 : MAXB;
        else                        model_cnt = 0;
        tot_cfg_pkts++;
      end else begin
        len = data_len_q.pop_front();
        for (int i = 0; i < len; i++) exp_q.push_back(data_model_q.pop_front());
        model_cnt = 0;
        tot_data_pkts++;
      end
    end
  endtask

  task automatic put_beat(input bit is_cfg, input beat_t b, input bit v);
    if (is_cfg) begin
      s_axis_cfg_tdata  = b.data;
      s_axis_cfg_tkeep  = b.keep;
      s_axis_cfg_tuser  = b.user;
      s_axis_cfg_tqid   = b.qid;
      s_axis_cfg_tlast  = b.last;
      s_axis_cfg_tvalid = v;
    end else begin
      s_axis_data_tdata  = b.data;
      s_axis_data_tkeep  = b.keep;
      s_axis_data_tuser  = b.user;
      s_axis_data_tqid   = b.qid;
      s_axis_data_tlast  = b.last;
      s_axis_data_tvalid = v;
    end
  endtask

  // Source driver: first beats go out back-to-back, later beats may have bubbles
  task automatic applyStimulus(input bit is_cfg);
    bit first = 1;
    while ((is_cfg ? cfg_drive_q.size() : data_drive_q.size()) != 0) begin
      beat_t b;
      bit    hs;
      int    t;
      b = is_cfg ? cfg_drive_q.pop_front() : data_drive_q.pop_front();
      if (!first && $urandom_range(0, 3) == 0) begin
        put_beat(is_cfg, rand_beat(1'b0), 1'b0);
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      put_beat(is_cfg, b, 1'b1);
      t = 0;
      do begin
        @(negedge clk);
        hs = is_cfg ? s_axis_cfg_tready : s_axis_data_tready;
        @(posedge clk);
        #1;
        t++;
      end while (!hs && t < 2000);
      if (!hs) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL handshake_timeout: port cfg=%0d got no tready, required tready", is_cfg);
        if (is_cfg) cfg_drive_q.delete();
        else        data_drive_q.delete();
      end
      first = b.last;
    end
    put_beat(is_cfg, '0, 1'b0);
  endtask

  // Wait for every expected beat to appear, then confirm the lock has been released
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    check_val("drain_remaining", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_val("idle_after_drain", 64'(arb_busy), 64'd0);
  endtask

  task automatic run_phase(input int nd, input int nc, input int fixed_len, input int mode, input bit measure);
    rdy_mode = mode;
    gen_packets(nd, nc, fixed_len);
    build_expected();
    @(posedge clk);
    #1;
    fork
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      begin
        if (measure) begin
          int n = 0;
          do begin
            @(posedge clk);
            #1;
            n++;
          end while (!m_axis_tvalid && n < 20);
          check_val("first_beat_latency", 64'(n), 64'd2);
        end
      end
    join
    drain();
  endtask

  // Downstream ready generator: always, random, or strict 1010 toggling
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 2) != 0);
      default: m_axis_tready = ~m_axis_tready;
    endcase
  end

  // Independent stall counter for the statistics check
  always @(negedge clk or negedge aresetn) begin
    if (!aresetn) tb_stall <= 0;
    else if (m_axis_tvalid && !m_axis_tready) tb_stall <= tb_stall + 1;
  end

  // Monitor: port exclusivity, stall stability, and in-order scoreboard matching
  always @(negedge clk) begin
    if (mon_en && aresetn) checkOutput();
  end

  task automatic checkOutput();
    beat_t cur;
    beat_t e;
    cur = '{data: m_axis_tdata, keep: m_axis_tkeep, user: m_axis_tuser,
            qid: m_axis_tqid, last: m_axis_tlast};
    check_val("tready_exclusive", 64'(s_axis_data_tready && s_axis_cfg_tready), 64'd0);
    if (prev_stall) begin
      n_checks++;
      if (!m_axis_tvalid || cur !== prev_beat) begin
        n_fails++;
        $display("[TB] FAIL stall_stable: got v=%0d %h required v=1 %h", m_axis_tvalid, cur, prev_beat);
      end
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_beat  = cur;
    if (m_axis_tvalid && m_axis_tready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("[TB] FAIL unexpected_beat: got %h required no beat", cur);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          n_fails++;
          $display("[TB] FAIL beat: got %h required %h", cur, e);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check_val({tag, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
    check_val({tag, "_m_tdata_or"}, 64'(|m_axis_tdata), 64'd0);
    check_val({tag, "_m_tkeep_or"}, 64'(|m_axis_tkeep), 64'd0);
    check_val({tag, "_m_tuser"}, 64'(m_axis_tuser), 64'd0);
    check_val({tag, "_m_tqid"}, 64'(m_axis_tqid), 64'd0);
    check_val({tag, "_data_tready"}, 64'(s_axis_data_tready), 64'd0);
    check_val({tag, "_cfg_tready"}, 64'(s_axis_cfg_tready), 64'd0);
    check_val({tag, "_arb_busy"}, 64'(arb_busy), 64'd0);
  endtask

  initial begin
    aresetn       = 1'b0;
    m_axis_tready = 1'b1;
    put_beat(1'b0, '0, 1'b0);
    put_beat(1'b1, '0, 1'b0);
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    check_val("idle_after_release", 64'(arb_busy), 64'd0);
    mon_en = 1;

    // Single 3-beat config packet with data idle, first beat two cycles after valid
    run_phase(0, 1, 3, 0, 1'b1);
    // Both ports loaded with 1-beat packets: burst of four configs then one data
    run_phase(3, 10, 1, 0, 1'b0);
    // One 4-beat data packet against a toggling downstream ready
    rdy_mode = 2;
    m_axis_tready = 1'b0;
    run_phase(1, 0, 4, 2, 1'b0);
    // Mixed lengths with bubbles and random backpressure
    for (int r = 0; r < 6; r++) begin
      run_phase($urandom_range(0, 5), $urandom_range(0, 9), 0, 1, 1'b0);
    end
    run_phase(5, 2, 0, 0, 1'b0);

`ifdef ARB_STATS_EN
    check_val("stat_data_pkts", 64'(stat_data_pkts), 64'(tot_data_pkts));
    check_val("stat_cfg_pkts", 64'(stat_cfg_pkts), 64'(tot_cfg_pkts));
    check_val("stat_stall_cyc", 64'(stat_stall_cyc), 64'(tb_stall));
`endif

    // Asynchronous reset in the middle of a config packet
    mon_en   = 0;
    rdy_mode = 0;
    put_beat(1'b1, rand_beat(1'b0), 1'b1);
    repeat (3) @(posedge clk);
    #3;
    check_val("pre_reset_busy", 64'(arb_busy), 64'd1);
    aresetn = 1'b0;
    #1;
    check_all_zero("midrun_reset");
`ifdef ARB_STATS_EN
    check_val("stat_cfg_after_reset", 64'(stat_cfg_pkts), 64'd0);
`endif
    put_beat(1'b1, '0, 1'b0);
    @(negedge clk);
    aresetn   = 1'b1;
    model_cnt = 0;
    @(posedge clk);
    #1;
    check_val("idle_after_midrun_reset", 64'(arb_busy), 64'd0);
    prev_stall = 0;
    mon_en = 1;

    // Traffic after reset still arbitrates from a clean burst count
    run_phase(2, 6, 1, 0, 1'b0);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
